// File: rtl/divider_pkg.sv
// Shared constants and helpers for the RTC one-second clock divider.
package divider_pkg;

    localparam int SYNC_STAGES   = 2;
    localparam int MIN_BASE_FREQ = 2;

    // Counter width, never narrower than one bit.
    function automatic int cnt_width(input int freq);
        int w;
        w = $clog2(freq);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/divider_trig_edge.sv
// Rising-edge detector for the re-phase trigger.
// DIVIDER_TRIG_SYNC_EN adds a 2-flop synchronizer ahead of the edge register.
module divider_trig_edge
    import divider_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic trig_rise
);

    logic trig_s;
    logic trig_q;

`ifdef DIVIDER_TRIG_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
    end

    assign trig_s = sync_q[SYNC_STAGES-1];
`else
    assign trig_s = trig;
`endif

    always_ff @(posedge clk) begin
        if (rst) trig_q <= 1'b0;
        else     trig_q <= trig_s;
    end

    assign trig_rise = trig_s & ~trig_q;

endmodule

// File: rtl/divider.sv
// Divides clk (BASE_FREQ Hz) to a one-cycle one_hz pulse; a rising trig restarts the interval.
// Optional trig synchronizer enabled by DIVIDER_TRIG_SYNC_EN.
module divider
    import divider_pkg::*;
#(
    parameter int BASE_FREQ = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic one_hz
);

    localparam int            CW = cnt_width(BASE_FREQ);
    localparam logic [CW-1:0] TC = CW'(BASE_FREQ - 1);

    generate
        if (BASE_FREQ < MIN_BASE_FREQ) begin : g_bad_freq
            $error("divider: BASE_FREQ must be >= 2");
        end
    endgenerate

    logic          trig_rise;
    logic [CW-1:0] cnt;

    divider_trig_edge u_trig_edge (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .trig_rise (trig_rise)
    );

    // A restart wins over a coinciding terminal count, so no pulse at the old phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            one_hz <= 1'b0;
        end else if (trig_rise) begin
            cnt    <= '0;
            one_hz <= 1'b0;
        end else if (cnt == TC) begin
            cnt    <= '0;
            one_hz <= 1'b1;
        end else begin
            cnt    <= cnt + CW'(1);
            one_hz <= 1'b0;
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (BASE_FREQ=4): per-edge vectors of {rst, trig, expected one_hz}.
// Vector trig values are as seen by the edge detector; the driver leads them by the trig latency.
module tb_divider;

  localparam int BASE_FREQ = 4;
  localparam time TIMEOUT  = 20us;
`ifdef DIVIDER_TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic rst;
    logic trig;
    logic want;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic trig;
  logic one_hz;
  logic done = 1'b0;

  vec_t v[$];
  int   checks = 0;
  int   passes = 0;

  divider #(.BASE_FREQ(BASE_FREQ)) dut (
    .clk    (clk),
    .rst    (rst),
    .trig   (trig),
    .one_hz (one_hz)
  );

  always #10 clk = ~clk;

  initial begin
    #(TIMEOUT);
    if (!done) begin
      $display("FAIL timeout: vector replay not finished after %0t", TIMEOUT);
      $finish;
    end
  end

  task automatic add(input logic r, input logic t, input logic w);
    vec_t e;
    e.rst  = r;
    e.trig = t;
    e.want = w;
    v.push_back(e);
  endtask

  initial begin
    int since;
    logic prev;

    rst  = 1'b1;
    trig = 1'b0;

    // Edge 0 samples rst; pulses then land on edges 4, 8, ... 40.
    add(1, 0, 0);
    for (int j = 1; j <= 40; j++) add(0, 0, (j % 4) == 0);

    // Edges 41-50: rise seen with cnt=1 at edge 42, old-phase pulse at 44 dropped.
    add(0, 0, 0);  // 41 cnt=1
    add(0, 1, 0);  // 42 restart
    add(0, 1, 0);  // 43
    add(0, 0, 0);  // 44 falling edge, no effect
    add(0, 0, 0);  // 45
    add(0, 0, 1);  // 46 restart + 4
    add(0, 0, 0);
    add(0, 0, 0);
    add(0, 0, 0);
    add(0, 0, 1);  // 50

    // Edges 51-66: trig held 11 cycles (one restart at 51), then low 5.
    for (int j = 51; j <= 61; j++) add(0, 1, (j == 55) || (j == 59));
    for (int j = 62; j <= 66; j++) add(0, 0, j == 63);

    // Edge 67: rise while cnt=3, terminal pulse suppressed; next pulse at 71.
    add(0, 1, 0);
    add(0, 0, 0);
    add(0, 0, 0);
    add(0, 0, 0);
    add(0, 0, 1);  // 71

    // Edge 72: rst while one_hz=1 and a trig rise pending; first pulse at 76.
    add(1, 1, 0);
    for (int j = 73; j <= 80; j++) add(0, 0, (j == 76) || (j == 80));

    // Random trig pulses; expected pulse every 4th edge after the last restart.
    since = 0;  // edge 80 was a pulse edge
    prev  = 1'b0;
    for (int p = 0; p < 17; p++) begin
      int lo = $urandom_range(2, 11);
      int hi = $urandom_range(2, 11);
      for (int j = 0; j < lo + hi; j++) begin
        logic t;
        logic w;
        t = (j >= lo);
        if (t && !prev) begin
          since = 0;
          w     = 1'b0;
        end else begin
          since = since + 1;
          w     = (since % 4) == 0;
        end
        add(0, t, w);
        prev = t;
      end
    end
    for (int j = 0; j < 6; j++) begin
      since = since + 1;
      add(0, 0, (since % 4) == 0);
    end

    for (int i = 0; i < v.size(); i++) begin
      rst  = v[i].rst;
      trig = (i + LAT < v.size()) ? v[i + LAT].trig : 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (one_hz === v[i].want) passes++;
      else $display("FAIL one_hz edge %0d: got %0b expected %0b", i, one_hz, v[i].want);
      if (v[i].rst) begin
        checks++;
        if ((one_hz === 1'b0) && (dut.cnt === '0)) passes++;
        else $display("FAIL reset state edge %0d: one_hz=%0b cnt=%0d", i, one_hz, dut.cnt);
      end
    end

    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
